// File: rtl/vga_compositor_pkg.sv
// Shared types, colour tables and helpers for the VGA layer compositor.
// Tables are sized for the default 12-bit R:G:B (4 bits per channel) packing.
package vga_compositor_pkg;

    localparam int unsigned PIX_W           = 12;
    localparam int unsigned CHAN_W          = 4;
    localparam int unsigned NUM_MASK_COLORS = 3;
    localparam int unsigned NUM_BARS        = 8;

    typedef enum logic [1:0] {
        BASE_CAMERA  = 2'b00,
        BASE_CHANNEL = 2'b01,
        BASE_THRESH  = 2'b10,
        BASE_MASKS   = 2'b11
    } base_mode_e;

    typedef enum logic [1:0] {
        OVL_ALL    = 2'b00,
        OVL_LAYER0 = 2'b01,
        OVL_UPPER  = 2'b10,
        OVL_BARS   = 2'b11
    } ovl_mode_e;

    localparam logic [PIX_W-1:0] MASK_COLOR [NUM_MASK_COLORS] = '{12'hA26, 12'h5C9, 12'h25E};

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam logic [PIX_W-1:0] TEST_BARS [NUM_BARS] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic logic [PIX_W-1:0] replicate_ch(input logic [CHAN_W-1:0] ch);
        return {ch, ch, ch};
    endfunction

endpackage

// File: rtl/vga_priority_select.sv
// Combinational selector: the lowest-index visible layer wins.
module vga_priority_select
    import vga_compositor_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = 12
) (
    input  logic [N-1:0]   vis_i,
    input  logic [N*W-1:0] pixel_i,
    output logic           hit_c_o,
    output logic [W-1:0]   pixel_c_o
);

    always_comb begin
        hit_c_o   = 1'b0;
        pixel_c_o = '0;
        // Walk from the lowest priority upward so the lowest index overwrites last
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vis_i[i]) begin
                hit_c_o   = 1'b1;
                pixel_c_o = pixel_i[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage base-layer select plus prioritised overlay compositor with frame-latched mode.
// Define VGA_COMPOSITOR_ALPHA_EN to blend layer 0 50/50 with the layer beneath in overlay mode 00.
module vga_layer_compositor
    import vga_compositor_pkg::*;
#(
    parameter int unsigned PIXEL_W      = 12,
    parameter int unsigned CH_W         = 4,
    parameter int unsigned NUM_MASKS    = 3,
    parameter int unsigned NUM_OVERLAYS = 4,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [3:0]                      sel_in,
    input  logic                            new_frame_in,
    input  logic [10:0]                     hcount_in,
    input  logic [9:0]                      vcount_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            blank_in,
    input  logic [PIXEL_W-1:0]              camera_pixel_in,
    input  logic [CH_W-1:0]                 camera_y_in,
    input  logic [CH_W-1:0]                 channel_in,
    input  logic [NUM_MASKS-1:0]            thresh_in,
    input  logic [NUM_OVERLAYS*PIXEL_W-1:0] overlay_pixel_in,
    input  logic [NUM_OVERLAYS-1:0]         overlay_en_in,
    input  logic [NUM_OVERLAYS-1:0]         blink_en_in,
    output logic [PIXEL_W-1:0]              pixel_out,
    output logic [10:0]                     hcount_out,
    output logic [9:0]                      vcount_out,
    output logic                            hsync_out,
    output logic                            vsync_out,
    output logic                            blank_out,
    output logic [3:0]                      active_sel_out
);

    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [3:0]                      active_sel_q, active_sel_d;
    logic [BLINK_W-1:0]              blink_cnt_q, blink_cnt_d;
    logic                            blink_phase_q, blink_phase_d;

    logic [3:0]                      s1_sel_q;
    logic [PIXEL_W-1:0]              s1_base_q, s1_base_d;
    logic [NUM_OVERLAYS-1:0]         s1_vis_q, s1_vis_d;
    logic [NUM_OVERLAYS*PIXEL_W-1:0] s1_ovl_q;
    logic [10:0]                     s1_hcount_q;
    logic [9:0]                      s1_vcount_q;
    logic                            s1_hsync_q, s1_vsync_q, s1_blank_q;

    logic [PIXEL_W-1:0]              pixel_q, pixel_d;
    logic [10:0]                     hcount_q;
    logic [9:0]                      vcount_q;
    logic                            hsync_q, vsync_q, blank_q;
    logic [3:0]                      out_sel_q;

    // Select latch and blink counter; the pulse pixel already sees the updated values
    always_comb begin
        active_sel_d  = active_sel_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (new_frame_in) begin
            active_sel_d = sel_in;
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Stage 1: base pixel and per-layer visibility
    always_comb begin
        s1_base_d = camera_pixel_in;
        case (base_mode_e'(active_sel_d[1:0]))
            BASE_CAMERA:  s1_base_d = camera_pixel_in;
            BASE_CHANNEL: s1_base_d = replicate_ch(channel_in);
            BASE_THRESH:  s1_base_d = thresh_in[0] ? '1 : '0;
            BASE_MASKS: begin
                s1_base_d = replicate_ch(camera_y_in);
                for (int i = int'(NUM_MASKS) - 1; i >= 0; i--) begin
                    if (thresh_in[i] && (i < int'(NUM_MASK_COLORS))) begin
                        s1_base_d = MASK_COLOR[i];
                    end
                end
            end
            default: s1_base_d = camera_pixel_in;
        endcase
        for (int i = 0; i < int'(NUM_OVERLAYS); i++) begin
            s1_vis_d[i] = overlay_en_in[i]
                        && (overlay_pixel_in[i*PIXEL_W +: PIXEL_W] != '0)
                        && !(blink_en_in[i] && blink_phase_d);
        end
    end

    logic                    all_hit, upper_hit;
    logic [PIXEL_W-1:0]      all_pix, upper_pix, layer0_pix, beneath_pix, result;
    logic [NUM_OVERLAYS-1:0] upper_vis;

    assign upper_vis  = s1_vis_q & ~NUM_OVERLAYS'(1);
    assign layer0_pix = s1_ovl_q[PIXEL_W-1:0];

    vga_priority_select #(.N(NUM_OVERLAYS), .W(PIXEL_W)) u_sel_all (
        .vis_i     (s1_vis_q),
        .pixel_i   (s1_ovl_q),
        .hit_c_o   (all_hit),
        .pixel_c_o (all_pix)
    );

    vga_priority_select #(.N(NUM_OVERLAYS), .W(PIXEL_W)) u_sel_upper (
        .vis_i     (upper_vis),
        .pixel_i   (s1_ovl_q),
        .hit_c_o   (upper_hit),
        .pixel_c_o (upper_pix)
    );

`ifdef VGA_COMPOSITOR_ALPHA_EN
    logic [CH_W:0] blend_sum;
`endif

    // Stage 2: overlay composition and blanking
    always_comb begin
        beneath_pix = upper_hit ? upper_pix : s1_base_q;
        result      = s1_base_q;
`ifdef VGA_COMPOSITOR_ALPHA_EN
        blend_sum   = '0;
`endif
        case (ovl_mode_e'(s1_sel_q[3:2]))
            OVL_ALL: begin
`ifdef VGA_COMPOSITOR_ALPHA_EN
                result = beneath_pix;
                if (s1_vis_q[0]) begin
                    for (int c = 0; c < 3; c++) begin
                        blend_sum = {1'b0, layer0_pix[c*CH_W +: CH_W]}
                                  + {1'b0, beneath_pix[c*CH_W +: CH_W]};
                        result[c*CH_W +: CH_W] = blend_sum[CH_W:1];
                    end
                end
`else
                result = all_hit ? all_pix : s1_base_q;
`endif
            end
            OVL_LAYER0: result = s1_vis_q[0] ? layer0_pix : s1_base_q;
            OVL_UPPER:  result = beneath_pix;
            OVL_BARS:   result = TEST_BARS[s1_hcount_q[9:7]];
            default:    result = s1_base_q;
        endcase
        pixel_d = s1_blank_q ? '0 : result;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active_sel_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            s1_sel_q      <= '0;
            s1_base_q     <= '0;
            s1_vis_q      <= '0;
            s1_ovl_q      <= '0;
            s1_hcount_q   <= '0;
            s1_vcount_q   <= '0;
            s1_hsync_q    <= 1'b0;
            s1_vsync_q    <= 1'b0;
            s1_blank_q    <= 1'b1;
            pixel_q       <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            blank_q       <= 1'b1;
            out_sel_q     <= '0;
        end else begin
            active_sel_q  <= active_sel_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            s1_sel_q      <= active_sel_d;
            s1_base_q     <= s1_base_d;
            s1_vis_q      <= s1_vis_d;
            s1_ovl_q      <= overlay_pixel_in;
            s1_hcount_q   <= hcount_in;
            s1_vcount_q   <= vcount_in;
            s1_hsync_q    <= hsync_in;
            s1_vsync_q    <= vsync_in;
            s1_blank_q    <= blank_in;
            pixel_q       <= pixel_d;
            hcount_q      <= s1_hcount_q;
            vcount_q      <= s1_vcount_q;
            hsync_q       <= s1_hsync_q;
            vsync_q       <= s1_vsync_q;
            blank_q       <= s1_blank_q;
            out_sel_q     <= s1_sel_q;
        end
    end

    assign pixel_out      = pixel_q;
    assign hcount_out     = hcount_q;
    assign vcount_out     = vcount_q;
    assign hsync_out      = hsync_q;
    assign vsync_out      = vsync_q;
    assign blank_out      = blank_q;
    assign active_sel_out = out_sel_q;

endmodule
